// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Front end for the ten number keys and two cursor keys of the text-LCD board.
//   Each raw button is synchronised and debounced. Each group is then reduced to a
//   clean one-hot (or all-zero) level, and a held cursor key is given auto-repeat.
//   The outputs drive the number_btn/control_btn inputs of the LCD cursor/write
//   controller.
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   asynchronous, active-high reset
//   number_raw   in  10   raw number keys, bit 9 = '1' ... bit 1 = '9', bit 0 = '0'
//   control_raw  in   2   raw cursor keys, bit 1 = Left, bit 0 = Right
//   number_btn   out 10   conditioned number level, one-hot or zero
//   control_btn  out  2   conditioned cursor level, one-hot or zero, dips low for repeats
//   press_strobe out  1   one-cycle pulse on every rising edge of either output group
//   multi_err    out  1   a group is idle and sees more than one debounced key pressed

module btn_conditioner #(
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] number_raw,
    input  logic [1:0] control_raw,
    output logic [9:0] number_btn,
    output logic [1:0] control_btn,
    output logic       press_strobe,
    output logic       multi_err
);

    localparam int DB_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {N_IDLE, N_ACTIVE, N_RELEASE} num_state_t;
    typedef enum logic [2:0] {C_IDLE, C_HOLD, C_GAP, C_REPEAT, C_RELEASE} ctl_state_t;

    // All twelve buttons are handled as one vector: number keys on top, cursor keys below.
    logic [11:0]     sync1_q, sync1_d;
    logic [11:0]     sync2_q, sync2_d;
    logic [11:0]     stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q [12];
    logic [DB_W-1:0] db_cnt_d [12];

    logic [9:0] num_stable;
    logic [1:0] ctl_stable;

    num_state_t       num_state_q;
    logic [9:0]       number_btn_q;
    logic             num_rise_q;
    logic             num_multi_q;

    ctl_state_t       ctl_state_q;
    logic [1:0]       control_btn_q;
    logic [1:0]       ctl_key_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             ctl_rise_q;
    logic             ctl_multi_q;

    // Synchroniser and per-bit debounce. A bit's counter only runs while the synced
    // value disagrees with the stable value. The stable bit flips on the
    // DEBOUNCE_CNT-th consecutive disagreeing cycle. The counter stops at
    // DEBOUNCE_CNT-1, so it can never wrap.
    always_comb begin
        sync1_d  = {number_raw, control_raw};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < 12; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] >= DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < 12; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int i = 0; i < 12; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign num_stable = stable_q[11:2];
    assign ctl_stable = stable_q[1:0];

    // Number group. While active, number_btn_q doubles as the latched key.
    // After a release, nothing new is accepted until every number key is up.
    // This stops a second key that is still held from producing a late press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_state_q  <= N_IDLE;
            number_btn_q <= '0;
            num_rise_q   <= 1'b0;
            num_multi_q  <= 1'b0;
        end else begin
            num_rise_q  <= 1'b0;
            num_multi_q <= 1'b0;
            case (num_state_q)
                N_IDLE: begin
                    if ($onehot(num_stable)) begin
                        number_btn_q <= num_stable;
                        num_rise_q   <= 1'b1;
                        num_state_q  <= N_ACTIVE;
                    end else if (num_stable != '0) begin
                        num_multi_q <= 1'b1;
                    end
                end
                N_ACTIVE: begin
                    if ((num_stable & number_btn_q) == '0) begin
                        number_btn_q <= '0;
                        num_state_q  <= N_RELEASE;
                    end
                end
                N_RELEASE: begin
                    if (num_stable == '0) begin
                        num_state_q <= N_IDLE;
                    end
                end
                default: begin
                    number_btn_q <= '0;
                    num_state_q  <= N_IDLE;
                end
            endcase
        end
    end

    // Cursor group with auto-repeat. The first hold phase lasts REPEAT_DELAY cycles.
    // Each later phase lasts REPEAT_RATE cycles. Every phase is followed by a single
    // low cycle, so the downstream controller sees a fresh edge. A release is checked
    // before count expiry, and also during the gap, so a released key never re-rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_state_q   <= C_IDLE;
            control_btn_q <= '0;
            ctl_key_q     <= '0;
            rpt_cnt_q     <= '0;
            ctl_rise_q    <= 1'b0;
            ctl_multi_q   <= 1'b0;
        end else begin
            ctl_rise_q  <= 1'b0;
            ctl_multi_q <= 1'b0;
            case (ctl_state_q)
                C_IDLE: begin
                    if ($onehot(ctl_stable)) begin
                        ctl_key_q     <= ctl_stable;
                        control_btn_q <= ctl_stable;
                        ctl_rise_q    <= 1'b1;
                        rpt_cnt_q     <= '0;
                        ctl_state_q   <= C_HOLD;
                    end else if (ctl_stable != '0) begin
                        ctl_multi_q <= 1'b1;
                    end
                end
                C_HOLD, C_REPEAT: begin
                    if ((ctl_stable & ctl_key_q) == '0) begin
                        control_btn_q <= '0;
                        ctl_state_q   <= C_RELEASE;
                    end else if (rpt_cnt_q >= ((ctl_state_q == C_HOLD) ? DELAY_LAST : RATE_LAST)) begin
                        control_btn_q <= '0;
                        ctl_state_q   <= C_GAP;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
                C_GAP: begin
                    if ((ctl_stable & ctl_key_q) == '0) begin
                        ctl_state_q <= C_RELEASE;
                    end else begin
                        control_btn_q <= ctl_key_q;
                        ctl_rise_q    <= 1'b1;
                        rpt_cnt_q     <= '0;
                        ctl_state_q   <= C_REPEAT;
                    end
                end
                C_RELEASE: begin
                    if (ctl_stable == '0) begin
                        ctl_state_q <= C_IDLE;
                    end
                end
                default: begin
                    control_btn_q <= '0;
                    ctl_state_q   <= C_IDLE;
                end
            endcase
        end
    end

    assign number_btn   = number_btn_q;
    assign control_btn  = control_btn_q;
    assign press_strobe = num_rise_q | ctl_rise_q;
    assign multi_err    = num_multi_q | ctl_multi_q;

endmodule
